// File: rtl/drp_pkg.sv
// Shared definitions for the multi-channel DRP register bridge: FSM states,
// default register map and status bit positions.
package drp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,     // read phase first when DRP_RMW_EN is defined
        S_WAIT,
        S_WR_ACCESS,  // read-modify-write second half
        S_WR_WAIT
    } drp_state_e;

    localparam int REG_DRP_ADDR   = 0;
    localparam int REG_DRP_DATA   = 1;
    localparam int REG_DRP_RESET  = 2;
    localparam int REG_DRP_STATUS = 3;
    localparam int REG_DRP_SEL    = 4;
    localparam int REG_DRP_MASK   = 5;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_TIMEOUT = 1;
    localparam int STAT_OVERRUN = 2;
    localparam int STAT_BADSEL  = 3;
    localparam int STAT_LASTWR  = 4;

endpackage

// File: rtl/drp_ch_mux.sv
// Channel steering: picks the selected channel's dout/drdy and turns the
// enable request into a one-hot den.
module drp_ch_mux #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 16
) (
    input  logic [2:0]               ch_sel,
    input  logic                     den_req,
    input  logic [NUM_CH*DATA_W-1:0] drp_dout,
    input  logic [NUM_CH-1:0]        drp_drdy,
    output logic [DATA_W-1:0]        dout_sel,
    output logic                     drdy_sel,
    output logic [NUM_CH-1:0]        den
);

    always_comb begin
        dout_sel = '0;
        drdy_sel = 1'b0;
        den      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_sel == 3'(k)) begin
                dout_sel = drp_dout[k*DATA_W +: DATA_W];
                drdy_sel = drp_drdy[k];
                den[k]   = den_req;
            end
        end
    end

endmodule

// File: rtl/reg_drp_multi.sv
// USB-register to multi-channel DRP bridge with drdy handshake, timeout and
// per-channel reset. Define DRP_RMW_EN to turn write commands into masked RMW.
module reg_drp_multi import drp_pkg::*; #(
    parameter int pBYTECNT_SIZE = 7,
    parameter int pNUM_CH       = 2,
    parameter int pADDR_W       = 7,
    parameter int pDATA_W       = 16,
    parameter int pTIMEOUT      = 255,
    parameter int pDRP_ADDR     = REG_DRP_ADDR,
    parameter int pDRP_DATA     = REG_DRP_DATA,
    parameter int pDRP_RESET    = REG_DRP_RESET,
    parameter int pDRP_STATUS   = REG_DRP_STATUS,
    parameter int pDRP_SEL      = REG_DRP_SEL,
    parameter int pDRP_MASK     = REG_DRP_MASK
) (
    input  logic                         clk_usb,
    input  logic                         reset_n,
    input  logic [7:0]                   reg_address,
    input  logic [pBYTECNT_SIZE-1:0]     reg_bytecnt,
    input  logic [7:0]                   reg_datai,
    output logic [7:0]                   reg_datao,
    input  logic                         reg_read,
    input  logic                         reg_write,
    input  logic                         selected,
    output logic [pADDR_W-1:0]           drp_addr,
    output logic [pDATA_W-1:0]           drp_din,
    output logic                         drp_dwe,
    output logic [pNUM_CH-1:0]           drp_den,
    input  logic [pNUM_CH*pDATA_W-1:0]   drp_dout,
    input  logic [pNUM_CH-1:0]           drp_drdy,
    output logic [pNUM_CH-1:0]           drp_reset
);

    localparam int NB = pDATA_W / 8;
    localparam int B  = $clog2(NB);
    localparam int BW = (B > 0) ? B : 1;
    localparam int TW = $clog2(pTIMEOUT + 1);

    drp_state_e           state_q, state_d;
    logic [2:0]           ch_sel_q, ch_sel_d;
    logic [pADDR_W-1:0]   addr_q, addr_d;
    logic                 is_wr_q, is_wr_d;
    logic [pDATA_W-1:0]   wdata_q, wdata_d;
    logic [pDATA_W-1:0]   rdata_q, rdata_d;
    logic [TW-1:0]        cnt_q, cnt_d;
    logic                 to_q, to_d, ov_q, ov_d, bs_q, bs_d;
    logic [pNUM_CH-1:0]   drp_reset_q, drp_reset_d;
    logic                 drdy_q;
    logic [pDATA_W-1:0]   dout_q;
`ifdef DRP_RMW_EN
    logic [pDATA_W-1:0]   mask_q, mask_d;
    logic [pDATA_W-1:0]   merge_q, merge_d;
    logic                 wr_mask;
`endif

    logic [5:0]           ra;
    logic                 wr_addr, wr_data, wr_rst, wr_stat, wr_sel, rd_en;
    logic [BW-1:0]        byte_idx;
    logic                 den_req, drdy_sel, drdy_ok, timeout_hit;
    logic [pDATA_W-1:0]   dout_sel;
    logic [7:0]           status;
    logic                 unused_ok;

    assign ra       = reg_address[5:0];
    assign wr_addr  = selected && reg_write && (ra == 6'(pDRP_ADDR));
    assign wr_data  = selected && reg_write && (ra == 6'(pDRP_DATA));
    assign wr_rst   = selected && reg_write && (ra == 6'(pDRP_RESET));
    assign wr_stat  = selected && reg_write && (ra == 6'(pDRP_STATUS));
    assign wr_sel   = selected && reg_write && (ra == 6'(pDRP_SEL));
    assign rd_en    = selected && reg_read;
    assign byte_idx = (B == 0) ? '0 : reg_bytecnt[BW-1:0];
    assign unused_ok = &{1'b0, reg_address[7:6], reg_bytecnt};
`ifdef DRP_RMW_EN
    assign wr_mask  = selected && reg_write && (ra == 6'(pDRP_MASK));
`endif

    drp_ch_mux #(.NUM_CH(pNUM_CH), .DATA_W(pDATA_W)) u_mux (
        .ch_sel   (ch_sel_q),
        .den_req  (den_req),
        .drp_dout (drp_dout),
        .drp_drdy (drp_drdy),
        .dout_sel (dout_sel),
        .drdy_sel (drdy_sel),
        .den      (drp_den)
    );

    // The return path is registered, so a drdy_q seen in the first WAIT cycle
    // stems from the ACCESS cycle and must be discarded.
    assign drdy_ok     = drdy_q && (cnt_q != '0);
    assign timeout_hit = (cnt_q == TW'(pTIMEOUT - 1));
    assign drp_addr    = addr_q;
    assign drp_reset   = drp_reset_q;
    assign status      = {3'b000, is_wr_q, bs_q, ov_q, to_q, state_q != S_IDLE};

    always_comb begin
        state_d     = state_q;
        ch_sel_d    = ch_sel_q;
        addr_d      = addr_q;
        is_wr_d     = is_wr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        to_d        = to_q;
        ov_d        = ov_q;
        bs_d        = bs_q;
        drp_reset_d = drp_reset_q;
        den_req     = 1'b0;
        drp_dwe     = 1'b0;
        drp_din     = '0;
`ifdef DRP_RMW_EN
        mask_d      = mask_q;
        merge_d     = merge_q;
        if (wr_mask)
            for (int i = 0; i < NB; i++)
                if (byte_idx == BW'(i)) mask_d[i*8 +: 8] = reg_datai;
`endif
        if (wr_sel) begin
            if ({1'b0, reg_datai[2:0]} < 4'(pNUM_CH)) ch_sel_d = reg_datai[2:0];
            else                                      bs_d     = 1'b1;
        end
        if (wr_data)
            for (int i = 0; i < NB; i++)
                if (byte_idx == BW'(i)) wdata_d[i*8 +: 8] = reg_datai;
        if (wr_rst)
            drp_reset_d = reg_datai[pNUM_CH-1:0];
        if (wr_stat) begin
            to_d = 1'b0;
            ov_d = 1'b0;
            bs_d = 1'b0;
        end
        if (wr_addr) begin
            if (state_q == S_IDLE) begin
                addr_d  = pADDR_W'(reg_datai[6:0]);
                is_wr_d = reg_datai[7];
                to_d    = 1'b0;
                state_d = S_ACCESS;
            end else begin
                ov_d = 1'b1;
            end
        end

        case (state_q)
            S_ACCESS: begin
                den_req = 1'b1;
                drp_din = wdata_q;
`ifndef DRP_RMW_EN
                drp_dwe = is_wr_q;
`endif
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + TW'(1);
                if (drdy_ok) begin
`ifdef DRP_RMW_EN
                    if (is_wr_q) begin
                        merge_d = (dout_q & ~mask_q) | (wdata_q & mask_q);
                        state_d = S_WR_ACCESS;
                    end else begin
                        rdata_d = dout_q;
                        state_d = S_IDLE;
                    end
`else
                    if (!is_wr_q) rdata_d = dout_q;
                    state_d = S_IDLE;
`endif
                end else if (timeout_hit) begin
                    rdata_d = '1;
                    to_d    = 1'b1;
                    state_d = S_IDLE;
                end
            end
`ifdef DRP_RMW_EN
            S_WR_ACCESS: begin
                den_req = 1'b1;
                drp_dwe = 1'b1;
                drp_din = merge_q;
                cnt_d   = '0;
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                cnt_d = cnt_q + TW'(1);
                if (drdy_ok) begin
                    state_d = S_IDLE;
                end else if (timeout_hit) begin
                    rdata_d = '1;
                    to_d    = 1'b1;
                    state_d = S_IDLE;
                end
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        reg_datao = '0;
        if (rd_en) begin
            if (ra == 6'(pDRP_ADDR))        reg_datao = {is_wr_q, 7'(addr_q)};
            else if (ra == 6'(pDRP_RESET))  reg_datao = 8'(drp_reset_q);
            else if (ra == 6'(pDRP_STATUS)) reg_datao = status;
            else if (ra == 6'(pDRP_SEL))    reg_datao = {5'b00000, ch_sel_q};
            else if (ra == 6'(pDRP_DATA)) begin
                for (int i = 0; i < NB; i++)
                    if (byte_idx == BW'(i)) reg_datao = rdata_q[i*8 +: 8];
            end
`ifdef DRP_RMW_EN
            else if (ra == 6'(pDRP_MASK)) begin
                for (int i = 0; i < NB; i++)
                    if (byte_idx == BW'(i)) reg_datao = mask_q[i*8 +: 8];
            end
`endif
        end
    end

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ch_sel_q    <= '0;
            addr_q      <= '0;
            is_wr_q     <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            to_q        <= 1'b0;
            ov_q        <= 1'b0;
            bs_q        <= 1'b0;
            drp_reset_q <= '0;
            drdy_q      <= 1'b0;
            dout_q      <= '0;
`ifdef DRP_RMW_EN
            mask_q      <= '1;
            merge_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ch_sel_q    <= ch_sel_d;
            addr_q      <= addr_d;
            is_wr_q     <= is_wr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            to_q        <= to_d;
            ov_q        <= ov_d;
            bs_q        <= bs_d;
            drp_reset_q <= drp_reset_d;
            drdy_q      <= drdy_sel;
            dout_q      <= dout_sel;
`ifdef DRP_RMW_EN
            mask_q      <= mask_d;
            merge_q     <= merge_d;
`endif
        end
    end

endmodule
